// File: rtl/jtpopeye_promload.sv
// ---------------------------------------------------------------------------------------------
// jtpopeye_promload
//
// Picks the colour-PROM bytes out of the ROM download stream and turns each one into a
// single-cycle write into one of the four colour-mixer PROMs (4a, 3a, 5b, 5a). It counts the
// bytes it accepts. When the download ends, it reports whether exactly the expected number of
// bytes arrived. Layer enables to the mixer are forced off while a load is in progress.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous, active-high reset
//   downloading  in   ROM download in progress
//   ioctl_addr   in   download byte address (22 bits)
//   ioctl_data   in   download byte
//   ioctl_wr     in   one-cycle byte-valid strobe
//   gfx_en_in    in   user layer enables {bak,obj,txt}
//   prog_addr    out  PROM write address (held between writes)
//   prom_din     out  PROM write data (held between writes)
//   prom_*_we    out  per-PROM write strobes, at most one high, one cycle after the byte
//   gfx_en       out  layer enables to the mixer, zero while busy (1-cycle latency)
//   prom_ok      out  full PROM set loaded by the last download
//   busy         out  high while a download is being captured
// ---------------------------------------------------------------------------------------------
module jtpopeye_promload #(
    parameter logic [21:0] PROM_START = 22'h1_8000,
    parameter int unsigned PROM_LEN   = 576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic [2:0]  gfx_en_in,
    output logic [7:0]  prog_addr,
    output logic [7:0]  prom_din,
    output logic        prom_4a_we,
    output logic        prom_3a_we,
    output logic        prom_5b_we,
    output logic        prom_5a_we,
    output logic [2:0]  gfx_en,
    output logic        prom_ok,
    output logic        busy
);

    localparam logic [21:0] LenAddr = 22'(PROM_LEN);
    localparam logic [9:0]  LenCnt  = 10'(PROM_LEN);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e      r_state;
    logic        r_dl_prev;
    logic [9:0]  r_cnt;
    logic [3:0]  r_we;          // {4a, 3a, 5b, 5a}
    logic [7:0]  r_prog_addr;
    logic [7:0]  r_prom_din;
    logic [2:0]  r_gfx_en;
    logic        r_prom_ok;

    logic [21:0] w_off;
    logic        w_in_range;
    logic        w_accept;
    logic        w_rise;
    logic        w_fall;
    logic [3:0]  w_sel;
    logic [7:0]  w_addr;

    // Addresses below PROM_START wrap to huge offsets, so one unsigned compare covers both ends.
    assign w_off      = ioctl_addr - PROM_START;
    assign w_in_range = (w_off < LenAddr);
    assign w_accept   = (r_state == StLoad) && ioctl_wr && downloading && w_in_range;
    assign w_rise     = downloading && !r_dl_prev;
    assign w_fall     = !downloading && r_dl_prev;

    // Region decode. 5b starts at 0x040 and 5a at 0x140; both bases have low byte 0x40, so
    // an 8-bit subtract yields the in-PROM address for either.
    always_comb begin
        w_sel  = 4'b0000;
        w_addr = 8'h00;
        if (w_off[9:0] < 10'h020) begin
            w_sel  = 4'b1000;
            w_addr = {3'b000, w_off[4:0]};
        end else if (w_off[9:0] < 10'h040) begin
            w_sel  = 4'b0100;
            w_addr = {3'b000, w_off[4:0]};
        end else if (w_off[9:0] < 10'h140) begin
            w_sel  = 4'b0010;
            w_addr = w_off[7:0] - 8'h40;
        end else begin
            w_sel  = 4'b0001;
            w_addr = w_off[7:0] - 8'h40;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_dl_prev   <= 1'b0;
            r_cnt       <= 10'd0;
            r_we        <= 4'b0000;
            r_prog_addr <= 8'h00;
            r_prom_din  <= 8'h00;
            r_gfx_en    <= 3'b000;
            r_prom_ok   <= 1'b0;
        end else begin
            r_dl_prev <= downloading;
            r_gfx_en  <= (r_state == StLoad) ? 3'b000 : gfx_en_in;
            r_we      <= 4'b0000;

            if (w_accept) begin
                r_we        <= w_sel;
                r_prog_addr <= w_addr;
                r_prom_din  <= ioctl_data;
                if (r_cnt != 10'h3FF) begin
                    r_cnt <= r_cnt + 10'd1;
                end
            end

            // Accepting needs LOAD, entering needs IDLE/DONE: the two counter writes never meet.
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_rise) begin
                        r_state   <= StLoad;
                        r_cnt     <= 10'd0;
                        r_prom_ok <= 1'b0;
                    end
                end
                StLoad: begin
                    if (w_fall) begin
                        r_state   <= StDone;
                        r_prom_ok <= (r_cnt == LenCnt);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign prog_addr  = r_prog_addr;
    assign prom_din   = r_prom_din;
    assign prom_4a_we = r_we[3];
    assign prom_3a_we = r_we[2];
    assign prom_5b_we = r_we[1];
    assign prom_5a_we = r_we[0];
    assign gfx_en     = r_gfx_en;
    assign prom_ok    = r_prom_ok;
    assign busy       = (r_state == StLoad);

endmodule
